iob_mem_responder: RTL and testbench
====================================

# iob_mem_responder

Responder end of the IOb native bus: a word-addressed on-chip memory that accepts single-beat read and write requests from an initiator such as the PicoRV32 wrapper's instruction or data bus. It owns `ready`, produces a one-cycle `rvalid` pulse after a programmable read latency, and inserts optional wait states after every access. It sits behind the bus split or interconnect as boot RAM, scratchpad, or a latency-configurable memory model for system simulation.

## Interface
- ADDR_W, 32, request byte-address width
- DATA_W, 32, data width; must be 32
- MEM_ADDR_W, 10, log2 of memory depth in words (1 KiW = 4 KiB)
- READ_LAT, 1, cycles from read acceptance to `rvalid`; legal range 1..4
- WAIT_STATES, 0, `ready`-low cycles inserted after each access completes; legal range 0..7

- clk_i  in  1  clock
- arst_i  in  1  reset; asynchronous, active-high
- cke_i  in  1  clock enable; when low, all state, including memory writes, is frozen
- iob_valid_i  in  1  request strobe; may be a single-cycle pulse
- iob_addr_i  in  ADDR_W  byte address
- iob_wdata_i  in  DATA_W  write data
- iob_wstrb_i  in  DATA_W/8  byte write strobes; all-zero means read
- iob_rdata_o  out  DATA_W  read data
- iob_rvalid_o  out  1  read-data-valid pulse
- iob_ready_o  out  1  responder can accept a request this cycle

## Operation
- Acceptance: `acc = iob_valid_i & iob_ready_o & cke_i`.
- A `valid` while `ready` is low is ignored: no memory change and no `rvalid`.
- Word index: `iob_addr_i[MEM_ADDR_W+1:2]`. Upper bits and `addr[1:0]` are ignored, so addresses alias modulo the depth.
- FSM states are IDLE, RD, and WAIT. `iob_ready_o = (state == IDLE)`, decoded combinationally from a registered state.
- IDLE, write accepted (`|wstrb`):
  - On the accepting edge, byte lane k is written iff `wstrb[k]`.
  - Next state is WAIT if WAIT_STATES>0, else IDLE.
  - No `rvalid` is produced. The initiator derives its own write acknowledge.
- IDLE, read accepted (`wstrb == 0`):
  - The memory word is captured into a READ_LAT-deep pipeline.
  - Next state is RD. A cycle counter is loaded with READ_LAT-1.
- RD:
  - The counter decrements each cycle.
  - In the cycle the counter is 0, `iob_rvalid_o` = 1 and `iob_rdata_o` = the captured word.
  - Next state is WAIT if WAIT_STATES>0, else IDLE.
- WAIT: the counter is loaded with WAIT_STATES-1 on entry, decrements each cycle, and the FSM returns to IDLE after the cycle in which the counter is 0.
- `iob_rdata_o` holds the last read data until the next `rvalid`.
- Data returned is the memory contents at the acceptance edge. A read accepted immediately after a write to the same word returns the new data.
- Memory contents are not reset and are undefined after power-up.

## Timing
- Reset values: state IDLE, `iob_ready_o` = 1, `iob_rvalid_o` = 0, `iob_rdata_o` = 0, counters 0.
- Reset mid-operation aborts any pending read: no `rvalid` is emitted and the FSM returns to IDLE. Memory writes already committed persist.
- Read accepted at edge T:
  - `ready` = 0 in cycles T+1 .. T+READ_LAT+WAIT_STATES.
  - `rvalid` = 1 only in cycle T+READ_LAT.
  - `ready` = 1 again at cycle T+READ_LAT+WAIT_STATES+1.
- Write accepted at edge T:
  - `ready` = 0 in cycles T+1 .. T+WAIT_STATES.
  - With WAIT_STATES = 0, `ready` stays high and back-to-back writes are accepted every cycle.
- At most one read is outstanding; a new request is never accepted while a read is in progress.
- `cke_i` low stretches every phase cycle-for-cycle. An `rvalid` that is high when `cke_i` drops stays high until `cke_i` returns and one enabled edge passes.
- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output.

## Test plan
- Reset then idle: assert `arst_i` asynchronously mid-cycle -> `ready` = 1, `rvalid` = 0, `rdata` = 0 immediately; outputs stay stable for 10 idle cycles.
- Write then read, READ_LAT=1, WAIT_STATES=0:
  - Stimulus: write 0xDEADBEEF to 0x40 with `wstrb` = 0xF; read 0x40 on the next cycle.
  - Required: `rvalid` exactly one cycle after read acceptance, `rdata` = 0xDEADBEEF, `ready` low only in that rvalid cycle.
- Partial strobes and aliasing, MEM_ADDR_W=10:
  - Stimulus: write 0x11223344 to 0x0; write 0xAABBCCDD with `wstrb` = 0b0101 to 0x1000, which aliases to word 0.
  - Required: a read of 0x0 returns 0x11BB33DD.
- Latency and wait states, READ_LAT=3, WAIT_STATES=2:
  - Stimulus: read accepted at edge T.
  - Required: `rvalid` only at T+3; `ready` low T+1..T+5 and high at T+6.
  - Additionally: a `valid` pulse at T+2 with write 0xFFFFFFFF is ignored, and memory is unchanged.
- Reset during read, READ_LAT=4:
  - Stimulus: read accepted; `arst_i` pulsed at T+2.
  - Required: no `rvalid` occurs, `ready` = 1 after reset, and a subsequent read returns the pre-reset contents.
- Clock-enable freeze:
  - Stimulus: READ_LAT=2 read accepted; `cke_i` held low for 3 cycles starting at T+1.
  - Required: `rvalid` appears 3 cycles later than nominal, lasts one enabled cycle, and returns correct data. Writes presented while `cke_i` = 0 do not modify memory.

Source files
------------

// File: rtl/iob_mem_responder.sv
// ---------------------------------------------------------------------------
// iob_mem_responder
//
// Word-addressed on-chip memory acting as the responder on an IOb native bus.
// Single-beat reads and writes are accepted only while the FSM is idle. A read
// produces a one-cycle rvalid pulse READ_LAT cycles after acceptance. An
// optional run of WAIT_STATES ready-low cycles follows every access.
//
// Ports:
//   clk_i         clock
//   arst_i        asynchronous active-high reset (memory contents not reset)
//   cke_i         clock enable; low freezes all state, memory writes included
//   iob_valid_i   request strobe
//   iob_addr_i    byte address; bits [MEM_ADDR_W+1:2] select the word
//   iob_wdata_i   write data
//   iob_wstrb_i   byte write strobes; all-zero means read
//   iob_rdata_o   read data, held between rvalid pulses
//   iob_rvalid_o  read-data-valid pulse
//   iob_ready_o   high while a request can be accepted
// ---------------------------------------------------------------------------
module iob_mem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_ADDR_W  = 10,
  parameter int READ_LAT    = 1,
  parameter int WAIT_STATES = 0
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                cke_i,
  input  logic                iob_valid_i,
  input  logic [ADDR_W-1:0]   iob_addr_i,
  input  logic [DATA_W-1:0]   iob_wdata_i,
  input  logic [DATA_W/8-1:0] iob_wstrb_i,
  output logic [DATA_W-1:0]   iob_rdata_o,
  output logic                iob_rvalid_o,
  output logic                iob_ready_o
);

  localparam int DEPTH = 1 << MEM_ADDR_W;
  localparam int NB    = DATA_W / 8;

  // Counter preload values; the wait preload is only used when WAIT_STATES > 0.
  localparam logic [2:0] RD_LOAD = 3'(READ_LAT - 1);
  localparam logic [2:0] WS_LOAD = 3'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT
  } state_t;

  state_t            state_reg;
  logic [2:0]        cnt_reg;
  logic [DATA_W-1:0] word_reg;   // registered memory read port
  logic [DATA_W-1:0] rdata_reg;  // last delivered read data

  logic [DATA_W-1:0] mem [DEPTH];

  logic [MEM_ADDR_W-1:0] word_idx;
  logic                  acc;
  logic                  wr_acc;
  logic                  rd_acc;

  // Address bits outside the word index are deliberately ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{iob_addr_i[ADDR_W-1:MEM_ADDR_W+2], iob_addr_i[1:0]};

  assign word_idx = iob_addr_i[MEM_ADDR_W+1:2];
  assign acc      = iob_valid_i & iob_ready_o & cke_i;
  assign wr_acc   = acc & (|iob_wstrb_i);
  assign rd_acc   = acc & ~(|iob_wstrb_i);

  // Byte-lane write port. Gated by acceptance, which already includes cke_i.
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (iob_wstrb_i[b]) begin
          mem[word_idx][b*8 +: 8] <= iob_wdata_i[b*8 +: 8];
        end
      end
    end
  end

  // Read port: the word is captured on the accepting edge and then held while
  // the latency counter runs. Only one read is ever outstanding, so a single
  // capture register carries the whole READ_LAT-deep latency.
  always_ff @(posedge clk_i) begin
    if (rd_acc) begin
      word_reg <= mem[word_idx];
    end
  end

  // Control FSM. Everything advances only on enabled edges, so a low cke_i
  // stretches each phase (including a pending rvalid) cycle-for-cycle.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 3'd0;
      rdata_reg <= '0;
    end else if (cke_i) begin
      case (state_reg)
        ST_IDLE: begin
          if (wr_acc) begin
            if (WAIT_STATES > 0) begin
              state_reg <= ST_WAIT;
              cnt_reg   <= WS_LOAD;
            end
          end else if (rd_acc) begin
            state_reg <= ST_RD;
            cnt_reg   <= RD_LOAD;
          end
        end
        ST_RD: begin
          if (cnt_reg == 3'd0) begin
            // rvalid cycle ends: keep the delivered word on the output.
            rdata_reg <= word_reg;
            if (WAIT_STATES > 0) begin
              state_reg <= ST_WAIT;
              cnt_reg   <= WS_LOAD;
            end else begin
              state_reg <= ST_IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg - 3'd1;
          end
        end
        ST_WAIT: begin
          if (cnt_reg == 3'd0) begin
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg - 3'd1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          cnt_reg   <= 3'd0;
        end
      endcase
    end
  end

  // Outputs are decoded from registers only; no input reaches an output.
  assign iob_ready_o  = (state_reg == ST_IDLE);
  assign iob_rvalid_o = (state_reg == ST_RD) && (cnt_reg == 3'd0);
  assign iob_rdata_o  = iob_rvalid_o ? word_reg : rdata_reg;

endmodule

// File: tb/tb_iob_mem_responder.sv
// ---------------------------------------------------------------------------
// Directed bench for iob_mem_responder. Four instances share the request
// inputs; each scenario checks the instance whose latency/wait configuration
// it targets:
//   [0] READ_LAT=1 WAIT_STATES=0   [1] READ_LAT=3 WAIT_STATES=2
//   [2] READ_LAT=4 WAIT_STATES=0   [3] READ_LAT=2 WAIT_STATES=0
// Inputs change and outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_iob_mem_responder;

  logic        clk;
  logic        rst;
  logic        cke;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  logic [31:0] rdata  [4];
  logic        rvalid [4];
  logic        ready  [4];

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  iob_mem_responder #(.ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(10), .READ_LAT(1), .WAIT_STATES(0)) u_l1w0 (
    .clk_i(clk), .arst_i(rst), .cke_i(cke), .iob_valid_i(valid), .iob_addr_i(addr),
    .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
    .iob_rdata_o(rdata[0]), .iob_rvalid_o(rvalid[0]), .iob_ready_o(ready[0]));

  iob_mem_responder #(.ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(10), .READ_LAT(3), .WAIT_STATES(2)) u_l3w2 (
    .clk_i(clk), .arst_i(rst), .cke_i(cke), .iob_valid_i(valid), .iob_addr_i(addr),
    .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
    .iob_rdata_o(rdata[1]), .iob_rvalid_o(rvalid[1]), .iob_ready_o(ready[1]));

  iob_mem_responder #(.ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(10), .READ_LAT(4), .WAIT_STATES(0)) u_l4w0 (
    .clk_i(clk), .arst_i(rst), .cke_i(cke), .iob_valid_i(valid), .iob_addr_i(addr),
    .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
    .iob_rdata_o(rdata[2]), .iob_rvalid_o(rvalid[2]), .iob_ready_o(ready[2]));

  iob_mem_responder #(.ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(10), .READ_LAT(2), .WAIT_STATES(0)) u_l2w0 (
    .clk_i(clk), .arst_i(rst), .cke_i(cke), .iob_valid_i(valid), .iob_addr_i(addr),
    .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
    .iob_rdata_o(rdata[3]), .iob_rvalid_o(rvalid[3]), .iob_ready_o(ready[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    wstrb = 4'h0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    valid = 1'b1;
    addr  = a;
    wdata = d;
    wstrb = s;
  endtask

  task automatic rd(input logic [31:0] a);
    valid = 1'b1;
    addr  = a;
    wdata = 32'h0;
    wstrb = 4'h0;
  endtask

  initial begin
    rst   = 1'b0;
    cke   = 1'b1;
    valid = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
    wstrb = 4'h0;

    // Asynchronous reset mid-cycle: outputs must respond before any edge.
    #3 rst = 1'b1;
    #1;
    check("rst_ready", ready[0], 1);
    check("rst_rvalid", rvalid[0], 0);
    check("rst_rdata", rdata[0], 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check("idle_ready", ready[0], 1);
      check("idle_rvalid", rvalid[0], 0);
      check("idle_rdata", rdata[0], 32'h0);
      step();
    end

    // Write then read next cycle, READ_LAT=1 WAIT_STATES=0.
    wr(32'h40, 32'hDEADBEEF, 4'hF);
    step();
    check("wr_ready_high", ready[0], 1);
    rd(32'h40);
    step();
    valid = 1'b0;
    check("l1_rvalid", rvalid[0], 1);
    check("l1_rdata", rdata[0], 32'hDEADBEEF);
    check("l1_ready_low", ready[0], 0);
    step();
    check("l1_rvalid_end", rvalid[0], 0);
    check("l1_ready_back", ready[0], 1);
    check("l1_rdata_hold", rdata[0], 32'hDEADBEEF);
    idle(8);

    // Partial strobes plus aliasing: 0x1000 maps onto word 0.
    wr(32'h0, 32'h11223344, 4'hF);
    step();
    wr(32'h1000, 32'hAABBCCDD, 4'b0101);
    step();
    rd(32'h0);
    step();
    valid = 1'b0;
    check("alias_rvalid", rvalid[0], 1);
    check("alias_rdata", rdata[0], 32'h11BB33DD);
    idle(8);

    // READ_LAT=3 WAIT_STATES=2, with an ignored write while busy.
    wr(32'h80, 32'h5A5A0001, 4'hF);
    step();
    idle(8);
    rd(32'h80);
    step();
    valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      check("l3w2_ready", ready[1], (c == 6) ? 1 : 0);
      check("l3w2_rvalid", rvalid[1], (c == 3) ? 1 : 0);
      if (c == 3) check("l3w2_rdata", rdata[1], 32'h5A5A0001);
      if (c == 2) wr(32'h80, 32'hFFFFFFFF, 4'hF);
      else valid = 1'b0;
      step();
    end
    rd(32'h80);
    step();
    valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check("l3w2_reread_rvalid", rvalid[1], (c == 3) ? 1 : 0);
      if (c == 3) check("l3w2_unchanged", rdata[1], 32'h5A5A0001);
      step();
    end
    idle(8);

    // READ_LAT=4, reset pulsed in cycle T+2 aborts the read.
    wr(32'hC0, 32'hCAFE0042, 4'hF);
    step();
    idle(8);
    rd(32'hC0);
    step();
    valid = 1'b0;
    check("l4_pre_rvalid", rvalid[2], 0);
    step();
    #3 rst = 1'b1;
    #1;
    check("l4_rst_ready", ready[2], 1);
    check("l4_rst_rvalid", rvalid[2], 0);
    check("l4_rst_rdata", rdata[2], 32'h0);
    #2 rst = 1'b0;
    step();
    for (int c = 1; c <= 6; c++) begin
      check("l4_no_rvalid", rvalid[2], 0);
      check("l4_ready", ready[2], 1);
      step();
    end
    rd(32'hC0);
    step();
    valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check("l4_rvalid", rvalid[2], (c == 4) ? 1 : 0);
      if (c == 4) check("l4_persist", rdata[2], 32'hCAFE0042);
      step();
    end
    idle(8);

    // Clock-enable freeze: READ_LAT=2 read, cke low for 3 cycles from T+1.
    wr(32'h100, 32'h0BADF00D, 4'hF);
    step();
    idle(8);
    rd(32'h100);
    step();
    valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      cke = (c <= 3) ? 1'b0 : 1'b1;
      check("cke_l2_rvalid", rvalid[3], (c == 5) ? 1 : 0);
      check("cke_l2_ready", ready[3], (c == 6) ? 1 : 0);
      if (c == 5) check("cke_l2_rdata", rdata[3], 32'h0BADF00D);
      check("cke_l1_rvalid_held", rvalid[0], (c <= 4) ? 1 : 0);
      if (c == 4) check("cke_l1_rdata", rdata[0], 32'h0BADF00D);
      step();
    end
    idle(8);

    // Writes presented with cke low must not reach memory.
    cke = 1'b0;
    wr(32'h100, 32'hFFFFFFFF, 4'hF);
    step();
    step();
    valid = 1'b0;
    cke   = 1'b1;
    step();
    rd(32'h100);
    step();
    valid = 1'b0;
    check("frz_l1_rdata", rdata[0], 32'h0BADF00D);
    check("frz_l2_pending", rvalid[3], 0);
    step();
    check("frz_l2_rvalid", rvalid[3], 1);
    check("frz_l2_rdata", rdata[3], 32'h0BADF00D);
    step();
    check("frz_l2_ready", ready[3], 1);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
